// File: rtl/clken_gen.sv
// Multi-channel fractional clock-enable generator: one phase accumulator per
// channel turns a single PLL clock into programmable-rate, phase-offset strobes.
module clken_gen #(
    parameter int                        NUM_CH        = 3,
    parameter int                        ACC_W         = 16,
    parameter logic [NUM_CH*ACC_W-1:0]   INIT_INC      = {3{16'h4000}},
    parameter logic [NUM_CH*ACC_W-1:0]   INIT_PHASE    = 48'h0,
    parameter int                        LOCK_CYCLES   = 16,
    parameter int                        GATE_UNLOCKED = 1
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [2:0]        cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    input  logic [ACC_W-1:0]  cfg_phase,
    output logic              cfg_err,
    input  logic              resync,
    output logic [NUM_CH-1:0] ce,
    output logic              locked
);

    localparam logic [15:0] LOCK_TGT = 16'(LOCK_CYCLES);
    localparam logic        GATE_EN  = (GATE_UNLOCKED != 0);

    logic              r_ready;
    logic              r_err;
    logic              r_locked;
    logic [15:0]       r_lock_cnt;
    logic [15:0]       w_lock_cnt_nxt;
    logic              w_accept;
    logic              w_ch_ok;
    logic              w_cfg_load;
    logic              w_relock;
    logic [NUM_CH-1:0] w_ce_raw;

    assign w_accept   = cfg_valid & r_ready;
    assign w_ch_ok    = ({1'b0, cfg_ch} < 4'(NUM_CH));
    assign w_cfg_load = w_accept & w_ch_ok;
    assign w_relock   = w_cfg_load | resync;

    // Channel datapath: carry out of the accumulator becomes the registered strobe
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [ACC_W-1:0] r_inc;
        logic [ACC_W-1:0] r_phase;
        logic [ACC_W-1:0] r_acc;
        logic             r_ce_raw;
        logic [ACC_W:0]   w_sum;
        logic             w_sel;

        assign w_sel       = w_cfg_load && (cfg_ch == 3'(g));
        assign w_sum       = {1'b0, r_acc} + {1'b0, r_inc};
        assign w_ce_raw[g] = r_ce_raw;

        always_ff @(posedge refclk) begin
            if (rst) begin
                r_inc    <= INIT_INC[g*ACC_W +: ACC_W];
                r_phase  <= INIT_PHASE[g*ACC_W +: ACC_W];
                r_acc    <= INIT_PHASE[g*ACC_W +: ACC_W];
                r_ce_raw <= 1'b0;
            end else if (w_sel) begin
                // A targeted write takes priority over resync for its own channel
                r_inc    <= cfg_inc;
                r_phase  <= cfg_phase;
                r_acc    <= cfg_phase;
                r_ce_raw <= 1'b0;
            end else if (resync) begin
                r_acc    <= r_phase;
                r_ce_raw <= 1'b0;
            end else begin
                r_acc    <= w_sum[ACC_W-1:0];
                r_ce_raw <= w_sum[ACC_W];
            end
        end
    end

    assign w_lock_cnt_nxt = (r_lock_cnt == LOCK_TGT) ? r_lock_cnt : r_lock_cnt + 16'd1;

    always_ff @(posedge refclk) begin
        if (rst || w_relock) begin
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
        end else begin
            r_lock_cnt <= w_lock_cnt_nxt;
            if (w_lock_cnt_nxt == LOCK_TGT) begin
                r_locked <= 1'b1;
            end
        end
    end

    // Ready drops for one cycle after every accept, valid channel or not
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ready <= ~w_accept;
            r_err   <= w_accept & ~w_ch_ok;
        end
    end

    assign cfg_ready = r_ready;
    assign cfg_err   = r_err;
    assign locked    = r_locked;
    assign ce        = w_ce_raw & ~{NUM_CH{GATE_EN & ~r_locked}};

endmodule
